// File: rtl/gmsk_tx_frontend_if.sv
// Sample/burst bus between tx_burst and the transmit output stage (strobes and I/Q in, DAC codes out).
// Latency: none, wiring only.
// Backpressure: none; the output stage always accepts samples on the strobes it is given.
interface gmsk_tx_frontend_if #(
  parameter int IN_WIDTH  = 6,
  parameter int DAC_WIDTH = 6
);
  logic                       sample_strobe;
  logic                       iq_valid;
  logic signed [IN_WIDTH-1:0] i_in;
  logic signed [IN_WIDTH-1:0] q_in;
  logic                       symbol_strobe;
  logic [DAC_WIDTH-1:0]       dac_i;
  logic [DAC_WIDTH-1:0]       dac_q;
  logic                       txchain_en;
  logic                       ramping;
  logic                       debug_strobe;

  // Sample source side: drives strobes and I/Q, observes the DAC pins and RF control.
  modport master (
    output sample_strobe, iq_valid, i_in, q_in, symbol_strobe,
    input  dac_i, dac_q, txchain_en, ramping, debug_strobe
  );

  // Output stage side.
  modport slave (
    input  sample_strobe, iq_valid, i_in, q_in, symbol_strobe,
    output dac_i, dac_q, txchain_en, ramping, debug_strobe
  );
endinterface

// File: rtl/gmsk_tx_frontend.sv
// Transmit output stage: ramps I/Q power at burst edges, emits offset-binary DAC codes, sequences txchain_en.
// Latency: 2 clocks from i_in/q_in to dac_i/dac_q; debug_strobe is symbol_strobe delayed DEBUG_DELAY clocks.
// Backpressure: none; every sample is consumed, ramp gain only advances on sample_strobe.
module gmsk_tx_frontend #(
  parameter int IN_WIDTH    = 6,
  parameter int DAC_WIDTH   = 6,
  parameter int RAMP_BITS   = 3,
  parameter int TXEN_LEAD   = 4,
  parameter int TXEN_LAG    = 4,
  parameter int DEBUG_DELAY = 3
) (
  input  logic              clock,
  input  logic              reset,
  gmsk_tx_frontend_if.slave bus
);

  localparam int SHIFT = DAC_WIDTH - IN_WIDTH;
  // Product width: DAC-wide sample times an unsigned gain of up to 2^RAMP_BITS, plus sign headroom.
  localparam int PW    = DAC_WIDTH + RAMP_BITS + 2;
  localparam int GW    = RAMP_BITS + 1;
  localparam int CW    = $clog2(TXEN_LEAD + TXEN_LAG + 2);

  localparam logic [GW-1:0]        GAIN_FULL = GW'(1 << RAMP_BITS);
  localparam logic [CW-1:0]        LEAD_LAST = (TXEN_LEAD > 0) ? CW'(TXEN_LEAD - 1) : '0;
  localparam logic [CW-1:0]        LAG_LAST  = (TXEN_LAG > 0) ? CW'(TXEN_LAG - 1) : '0;
  localparam logic signed [PW-1:0] MID       = PW'((1 << (DAC_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] CODE_MAX  = PW'((1 << DAC_WIDTH) - 1);
  localparam logic [DAC_WIDTH-1:0] MID_CODE  = DAC_WIDTH'((1 << (DAC_WIDTH - 1)) - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    RAMP_UP,
    ON,
    RAMP_DOWN,
    LAG
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          gain_q, gain_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   txen_q;
  logic                   ramp_q;

  logic signed [DAC_WIDTH-1:0] ext_i, ext_q;
  logic signed [PW-1:0]        gain_s;
  logic signed [PW-1:0]        mult_i, mult_q;
  logic signed [PW-1:0]        prod_i_q, prod_q_q;
  logic [DAC_WIDTH-1:0]        dac_i_q, dac_q_q;
  logic [DEBUG_DELAY-1:0]      dbg_sr;

  // Arithmetic shift by RAMP_BITS (floor), re-centre on MID, clamp to the DAC code range.
  function automatic logic [DAC_WIDTH-1:0] to_code(input logic signed [PW-1:0] prod);
    logic signed [PW-1:0] sum;
    sum = (prod >>> RAMP_BITS) + MID;
    if (sum[PW-1]) begin
      to_code = '0;
    end else if (sum > CODE_MAX) begin
      to_code = '1;
    end else begin
      to_code = sum[DAC_WIDTH-1:0];
    end
  endfunction

  // Burst sequencing: guard time, ramp up, hold, ramp down, guard time; gain moves one step per sample strobe.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gain_d = '0;
        if (bus.iq_valid) begin
          cnt_d   = '0;
          state_d = (TXEN_LEAD == 0) ? RAMP_UP : LEAD;
        end
      end
      LEAD: begin
        if (!bus.iq_valid) begin
          cnt_d   = '0;
          state_d = (TXEN_LAG == 0) ? IDLE : LAG;
        end else if (cnt_q == LEAD_LAST) begin
          state_d = RAMP_UP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RAMP_UP: begin
        if (!bus.iq_valid) begin
          // Nothing to ramp down from if no step was taken yet.
          if (gain_q == '0) begin
            cnt_d   = '0;
            state_d = (TXEN_LAG == 0) ? IDLE : LAG;
          end else begin
            state_d = RAMP_DOWN;
          end
        end else if (bus.sample_strobe) begin
          gain_d = gain_q + 1'b1;
          if (gain_d == GAIN_FULL) begin
            state_d = ON;
          end
        end
      end
      ON: begin
        if (!bus.iq_valid) begin
          state_d = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        // iq_valid is deliberately ignored here: a burst restart waits for IDLE.
        if (bus.sample_strobe) begin
          gain_d = gain_q - 1'b1;
          if (gain_d == '0) begin
            cnt_d   = '0;
            state_d = (TXEN_LAG == 0) ? IDLE : LAG;
          end
        end
      end
      LAG: begin
        if (cnt_q == LAG_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gain_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, gain and guard counter; txchain_en and ramping are registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gain_q  <= '0;
      cnt_q   <= '0;
      txen_q  <= 1'b0;
      ramp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      txen_q  <= (state_d != IDLE);
      ramp_q  <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end
  end

  assign ext_i  = DAC_WIDTH'(bus.i_in) <<< SHIFT;
  assign ext_q  = DAC_WIDTH'(bus.q_in) <<< SHIFT;
  assign gain_s = PW'({1'b0, gain_q});
  assign mult_i = PW'(ext_i) * gain_s;
  assign mult_q = PW'(ext_q) * gain_s;

  // Two-stage datapath: stage 1 holds the gain product, stage 2 the offset/saturated code.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_i_q <= '0;
      prod_q_q <= '0;
      dac_i_q  <= MID_CODE;
      dac_q_q  <= MID_CODE;
    end else begin
      prod_i_q <= mult_i;
      prod_q_q <= mult_q;
      dac_i_q  <= to_code(prod_i_q);
      dac_q_q  <= to_code(prod_q_q);
    end
  end

  // Debug pin path: plain shift register, unrelated to burst state.
  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_sr <= '0;
    end else begin
      dbg_sr[0] <= bus.symbol_strobe;
      for (int k = 1; k < DEBUG_DELAY; k++) begin
        dbg_sr[k] <= dbg_sr[k-1];
      end
    end
  end

  assign bus.dac_i        = dac_i_q;
  assign bus.dac_q        = dac_q_q;
  assign bus.txchain_en   = txen_q;
  assign bus.ramping      = ramp_q;
  assign bus.debug_strobe = dbg_sr[DEBUG_DELAY-1];

endmodule
